// File: rtl/mask_zone_counter.sv
// Purpose: counts masked pixels per band of the frame and reports hysteretic per-band detection flags plus the strongest band.
// Latency: a beat lands in its accumulator 1 cycle later; totals latch 1 cycle after frame_done_in, and flags/best zone follow 1 cycle after that.
// Backpressure: none; one beat per cycle is always accepted.
//
// Ports:
//   clk_in, rst_in        single clock, asynchronous active-high reset
//   mask_valid_in/mask_in mask beat and its threshold bit
//   hcount_in/vcount_in   pixel coordinates of the beat
//   frame_done_in         single-cycle end-of-frame pulse
//   on_thresh_in          detection set threshold (count must exceed it)
//   off_thresh_in         detection clear threshold (count must fall below it)
//   zone_count_out        latched per-zone totals, zone k at [k*CNT_WIDTH +: CNT_WIDTH]
//   detected_out          per-zone detection flags
//   best_zone_out         index of the zone with the largest latched total
//   result_valid_out      one-cycle pulse when detected_out/best_zone_out update
module mask_zone_counter #(
    parameter int H_WIDTH      = 9,
    parameter int V_WIDTH      = 8,
    parameter int NUM_ZONES    = 2,
    parameter int ZONE_AXIS    = 1,
    parameter int FRAME_EXTENT = 320,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           mask_valid_in,
    input  logic                           mask_in,
    input  logic [H_WIDTH-1:0]             hcount_in,
    input  logic [V_WIDTH-1:0]             vcount_in,
    input  logic                           frame_done_in,
    input  logic [CNT_WIDTH-1:0]           on_thresh_in,
    input  logic [CNT_WIDTH-1:0]           off_thresh_in,
    output logic [NUM_ZONES*CNT_WIDTH-1:0] zone_count_out,
    output logic [NUM_ZONES-1:0]           detected_out,
    output logic [2:0]                     best_zone_out,
    output logic                           result_valid_out
);

    // Coordinate along the split axis, widened so band limits compare without truncation.
    logic [31:0] coord;
    assign coord = (ZONE_AXIS != 0) ? 32'(vcount_in) : 32'(hcount_in);

    logic [NUM_ZONES-1:0] hit;
    logic [CNT_WIDTH-1:0] cnt_arr [NUM_ZONES];

    // Stage-2 trigger: set the cycle after a latch so thresholds see the new totals.
    logic latch_vld_q;

    for (genvar k = 0; k < NUM_ZONES; k++) begin : g_zone
        // Band limits are fixed at elaboration; the last upper limit equals
        // FRAME_EXTENT, so coordinates beyond the frame hit no band.
        localparam int LO = k * FRAME_EXTENT / NUM_ZONES;
        localparam int HI = (k + 1) * FRAME_EXTENT / NUM_ZONES;

        if (k == 0) begin : g_first
            assign hit[k] = (coord < 32'(HI));
        end else begin : g_rest
            assign hit[k] = (coord >= 32'(LO)) && (coord < 32'(HI));
        end

        logic                 inc;
        logic [CNT_WIDTH-1:0] acc_q;
        logic [CNT_WIDTH-1:0] acc_nxt;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 det_q;

        assign inc = mask_valid_in & mask_in & hit[k];

        // Saturate at all-ones instead of wrapping.
        assign acc_nxt = (inc && (acc_q != '1)) ? acc_q + CNT_WIDTH'(1) : acc_q;

        // A beat coincident with frame_done_in is folded into the latched total
        // through acc_nxt, and the accumulator restarts from zero.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (frame_done_in) begin
                acc_q <= '0;
                cnt_q <= acc_nxt;
            end else begin
                acc_q <= acc_nxt;
            end
        end

        // Hysteresis: set above on, clear below off, otherwise hold.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                det_q <= 1'b0;
            end else if (latch_vld_q) begin
                if (cnt_q > on_thresh_in) begin
                    det_q <= 1'b1;
                end else if (cnt_q < off_thresh_in) begin
                    det_q <= 1'b0;
                end
            end
        end

        assign cnt_arr[k]                                = cnt_q;
        assign zone_count_out[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign detected_out[k]                           = det_q;
    end

    // Argmax over the latched totals; strict '>' keeps the lowest index on ties,
    // and all-zero totals naturally resolve to zone 0.
    logic [2:0]           best_idx;
    logic [CNT_WIDTH-1:0] best_cnt;

    always_comb begin
        best_idx = 3'd0;
        best_cnt = cnt_arr[0];
        for (int k = 1; k < NUM_ZONES; k++) begin
            if (cnt_arr[k] > best_cnt) begin
                best_cnt = cnt_arr[k];
                best_idx = 3'(k);
            end
        end
    end

    // Back-to-back frame_done_in pulses give back-to-back latch_vld_q cycles,
    // so each latched set of totals gets its own result pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            latch_vld_q      <= 1'b0;
            result_valid_out <= 1'b0;
            best_zone_out    <= 3'd0;
        end else begin
            latch_vld_q      <= frame_done_in;
            result_valid_out <= latch_vld_q;
            if (latch_vld_q) begin
                best_zone_out <= best_idx;
            end
        end
    end

endmodule

// File: doc/mask_zone_counter.md
# mask_zone_counter

Parametrised successor to the two-zone red-dot detector. Consumes the per-pixel threshold mask stream (mask bit plus recovered pixel coordinates) and splits the frame into `NUM_ZONES` equal bands along a selectable axis. It counts masked pixels per band, latches the totals at end of frame, and produces per-zone detection flags with hysteresis plus the index of the strongest zone. It sits after the threshold stage and feeds the motor and behaviour logic.

## Interface
- `H_WIDTH`, 9, width of `hcount_in`
- `V_WIDTH`, 8, width of `vcount_in`
- `NUM_ZONES`, 2, band count; legal range 1..8
- `ZONE_AXIS`, 1, 0 = bands split along hcount, 1 = along vcount
- `FRAME_EXTENT`, 320, extent of the split axis in pixels; must be ≥ `NUM_ZONES`
- `CNT_WIDTH`, 16, per-zone counter width
- `clk_in` input 1: single clock; all logic on posedge
- `rst_in` input 1: reset, asynchronous, active-high
- `mask_valid_in` input 1: mask/coordinate beat valid this cycle
- `mask_in` input 1: threshold mask bit for the pixel
- `hcount_in` input `H_WIDTH`: pixel column
- `vcount_in` input `V_WIDTH`: pixel row
- `frame_done_in` input 1: single-cycle end-of-frame pulse
- `on_thresh_in` input `CNT_WIDTH`: detection set threshold
- `off_thresh_in` input `CNT_WIDTH`: detection clear threshold (≤ `on_thresh_in`)
- `zone_count_out` output `NUM_ZONES*CNT_WIDTH`: latched per-zone totals; zone k occupies bits [k*CNT_WIDTH +: CNT_WIDTH]
- `detected_out` output `NUM_ZONES`: per-zone hysteretic detection flags
- `best_zone_out` output 3: index of the zone with the largest latched count
- `result_valid_out` output 1: one-cycle pulse when `detected_out` and `best_zone_out` update

## Operation
- The coordinate `c` is `vcount_in` when `ZONE_AXIS`=1, otherwise `hcount_in`.
- Zone boundaries are elaboration-time constants: B[k] = k*FRAME_EXTENT/NUM_ZONES (integer divide). The pixel belongs to zone k when B[k] ≤ c < B[k+1]. There is no runtime divider; boundaries are compared directly.
- A pixel with c ≥ `FRAME_EXTENT` is ignored and counts toward no zone.
- Accumulate: on `mask_valid_in`=1, the zone accumulator for the pixel's zone adds `mask_in`. Accumulators saturate at all-ones and never wrap.
- End of frame: on `frame_done_in`=1:
  - Each zone total (including any beat valid in the same cycle) is copied into the `zone_count_out` registers.
  - All accumulators are cleared to 0.
- Stage 2, the cycle after the latch:
  - Per zone k with latched count C: if C > `on_thresh_in`, `detected_out[k]`←1. Else if C < `off_thresh_in`, `detected_out[k]`←0. Otherwise it holds its previous value.
  - `best_zone_out` ← argmax of C; ties resolve to the lowest index; all-zero counts give 0.
  - `result_valid_out` pulses.
- Thresholds are sampled in stage 2 only; changing them mid-frame is legal.
- Back-to-back `frame_done_in` pulses on consecutive cycles:
  - Each pulse is processed.
  - The second latch captures only beats arriving between the two pulses.
  - The result stages pipeline without loss.

## Timing
- Reset (async assert, sync release) clears all outputs to 0: `zone_count_out`, `detected_out`, `best_zone_out`, `result_valid_out`. All accumulators and pipeline valid bits are also cleared.
- Accumulation latency: a beat is reflected in its accumulator the cycle after it is presented.
- `frame_done_in` at cycle t gives:
  - `zone_count_out` updated at t+1.
  - `detected_out`, `best_zone_out` updated and `result_valid_out`=1 at t+2, for exactly one cycle.
- A beat coincident with `frame_done_in` is counted in the closing frame and is not carried into the next.
- Reset asserted mid-frame discards the partial counts. The first frame after reset starts from zeroed accumulators with `detected_out`=0 as the hysteresis history.
- No backpressure: the block always accepts input, one beat per cycle maximum.

## Test plan
- Defaults (2 zones, vcount split, extent 320), on=0x0700, off=0x0600. Send 2000 masked beats at vcount 10 and 100 at vcount 200, then pulse `frame_done_in` → at t+1, zone0=2000 and zone1=100; at t+2, `detected_out`=2'b01, `best_zone_out`=0, `result_valid_out` high for one cycle.
- Hysteresis, on=100, off=50. Zone0 counts per frame 150, 80, 40 → `detected_out[0]` is 1, 1, 0 across the three results.
- `NUM_ZONES`=5, `ZONE_AXIS`=0, extent 320. One masked beat at each hcount 63, 64, 319, 320 → counts [1,1,0,0,1]; the hcount-320 beat is ignored.
- Saturation with `CNT_WIDTH`=4. 20 masked beats into zone 1 → zone1 reads 15, not 4.
- Coincident events. A masked beat in zone 0 on the same cycle as `frame_done_in` counts in the closing frame, and the next frame's zone0 starts at 0. Equal counts of 7 in zones 0 and 1 → `best_zone_out`=0.
- Assert `rst_in` mid-frame after 30 beats, then run a frame of 5 beats → latched count is 5 and all outputs are 0 while reset is held.
